// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - inter-stage register with valid/ready handshake, 2-entry skid buffer, flush and bubble masking
// Optional performance counters enabled by defining PIPE_STAGE_SKID_PERF_EN.
module pipe_stage_skid_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 3,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd
`ifdef PIPE_STAGE_SKID_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       xfer_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [RD_W-1:0]   main_rd_q, main_rd_d, skid_rd_q, skid_rd_d;
  logic              acc, snd;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign acc       = in_valid & in_ready_q;
  assign snd       = out_valid & out_ready;
  assign out_ctrl  = main_ctrl_q & {CTRL_W{out_valid}};
  assign out_data  = main_data_q;
  assign out_rd    = main_rd_q;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    main_rd_d   = main_rd_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    skid_rd_d   = skid_rd_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d     = BUSY;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            main_rd_d   = in_rd;
          end
        end
        BUSY: begin
          if (acc && !snd) begin
            state_d     = FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            skid_rd_d   = in_rd;
          end else if (acc && snd) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            main_rd_d   = in_rd;
          end else if (snd) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // Skid entry is always older than anything upstream, so it refills main first.
          if (snd) begin
            state_d     = BUSY;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            main_rd_d   = skid_rd_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      main_rd_q   <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_rd_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      main_rd_q   <= main_rd_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_rd_q   <= skid_rd_d;
    end
  end

`ifdef PIPE_STAGE_SKID_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    xfer_cnt_d   = xfer_cnt_q;
    if (in_valid && !in_ready_q && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (!out_valid && (bubble_cnt_q != 32'hFFFF_FFFF))
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    if (snd && (xfer_cnt_q != 32'hFFFF_FFFF))
      xfer_cnt_d = xfer_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      xfer_cnt_q   <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      xfer_cnt_q   <= xfer_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign xfer_cnt   = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - self-checking bench for pipe_stage_skid_reg
// Queue model checked every cycle plus directed literal expectations.
module tb_pipe_stage_skid_reg;

  localparam int DATA_W = 96;
  localparam int CTRL_W = 3;
  localparam int RD_W   = 5;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic [RD_W-1:0]   in_rd = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [RD_W-1:0]   out_rd;
`ifdef PIPE_STAGE_SKID_PERF_EN
  logic [31:0]       stall_cnt, bubble_cnt, xfer_cnt;
  int unsigned       m_stall = 0, m_bubble = 0, m_xfer = 0;
  int unsigned       base;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ent_t mq[$];
  bit   ready_m = 1'b1;
  bit   m_acc, m_snd;

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_rd(out_rd)
`ifdef PIPE_STAGE_SKID_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .xfer_cnt(xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a FIFO of at most two entries; the head is what the outputs present.
  always @(negedge rst_n) begin
    mq.delete();
    ready_m = 1'b1;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      m_acc = in_valid && ready_m;
      m_snd = (mq.size() > 0) && out_ready;
`ifdef PIPE_STAGE_SKID_PERF_EN
      if (in_valid && !ready_m) m_stall++;
      if (mq.size() == 0) m_bubble++;
      if (m_snd) m_xfer++;
`endif
      if (flush) begin
        mq.delete();
      end else begin
        if (m_snd) void'(mq.pop_front());
        if (m_acc) mq.push_back('{ctrl: in_ctrl, data: in_data, rd: in_rd});
      end
      ready_m = (mq.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_out_valid", 128'(out_valid), 128'(mq.size() > 0));
      chk("model_in_ready", 128'(in_ready), 128'(ready_m));
      chk("model_out_ctrl", 128'(out_ctrl), (mq.size() > 0) ? 128'(mq[0].ctrl) : 128'd0);
      if (mq.size() > 0) begin
        chk("model_out_data", 128'(out_data), 128'(mq[0].data));
        chk("model_out_rd", 128'(out_rd), 128'(mq[0].rd));
      end
`ifdef PIPE_STAGE_SKID_PERF_EN
      chk("model_stall_cnt", 128'(stall_cnt), 128'(m_stall));
      chk("model_bubble_cnt", 128'(bubble_cnt), 128'(m_bubble));
      chk("model_xfer_cnt", 128'(xfer_cnt), 128'(m_xfer));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d, input logic [RD_W-1:0] r);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
    in_rd    = r;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    chk("reset_out_ctrl", 128'(out_ctrl), 128'd0);
    chk("reset_out_data", 128'(out_data), 128'd0);
    chk("reset_out_rd", 128'(out_rd), 128'd0);
    rst_n = 1'b1;
    tick();

    // Streaming
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'b101, DATA_W'(i), RD_W'(i));
      tick();
      chk("stream_out_data", 128'(out_data), 128'(i));
      chk("stream_out_valid", 128'(out_valid), 128'd1);
      chk("stream_out_ctrl", 128'(out_ctrl), 128'b101);
      chk("stream_in_ready", 128'(in_ready), 128'd1);
    end
    drive(1'b0, '0, '0, '0);
    tick();
    chk("stream_drained", 128'(out_valid), 128'd0);

    // Backpressure
    out_ready = 1'b0;
    drive(1'b1, 3'b011, DATA_W'(32'h11), 5'd1);
    tick();
    drive(1'b1, 3'b010, DATA_W'(32'h22), 5'd2);
    tick();
    chk("bp_full_in_ready", 128'(in_ready), 128'd0);
    chk("bp_full_out_data", 128'(out_data), 128'h11);
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b1;
    tick();
    chk("bp_second_out_data", 128'(out_data), 128'h22);
    chk("bp_second_out_rd", 128'(out_rd), 128'd2);
    tick();
    chk("bp_empty", 128'(out_valid), 128'd0);

    // Flush while full, with a live upstream entry
    out_ready = 1'b0;
    drive(1'b1, 3'b001, DATA_W'(32'h44), 5'd4);
    tick();
    drive(1'b1, 3'b001, DATA_W'(32'h55), 5'd5);
    tick();
`ifdef PIPE_STAGE_SKID_PERF_EN
    base = stall_cnt;
    drive(1'b1, 3'b001, DATA_W'(32'h66), 5'd6);
    repeat (4) tick();
    chk("perf_stall_4", 128'(stall_cnt - base), 128'd4);
`endif
    drive(1'b1, 3'b100, DATA_W'(32'h33), 5'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    chk("flush_out_valid", 128'(out_valid), 128'd0);
    chk("flush_out_ctrl", 128'(out_ctrl), 128'd0);
    chk("flush_in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    tick();
    chk("flush_no_0x33", 128'(out_valid), 128'd0);

    // Bubble masking
    drive(1'b1, 3'b111, DATA_W'(32'h77), 5'd7);
    tick();
    chk("bubble_live_ctrl", 128'(out_ctrl), 128'b111);
    drive(1'b0, '0, '0, '0);
    tick();
    chk("bubble_out_valid", 128'(out_valid), 128'd0);
    chk("bubble_out_ctrl", 128'(out_ctrl), 128'd0);

`ifdef PIPE_STAGE_SKID_PERF_EN
    base = xfer_cnt;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'b001, DATA_W'(i + 100), 5'd9);
      tick();
    end
    drive(1'b0, '0, '0, '0);
    tick();
    chk("perf_xfer_10", 128'(xfer_cnt - base), 128'd10);
`endif

    // Asynchronous reset while full
    out_ready = 1'b0;
    drive(1'b1, 3'b110, DATA_W'(32'h88), 5'd8);
    tick();
    drive(1'b1, 3'b110, DATA_W'(32'h99), 5'd9);
    tick();
    drive(1'b0, '0, '0, '0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_out_valid", 128'(out_valid), 128'd0);
    chk("areset_out_data", 128'(out_data), 128'd0);
    chk("areset_out_ctrl", 128'(out_ctrl), 128'd0);
    tick();
    rst_n = 1'b1;
    chk("areset_in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    drive(1'b1, 3'b101, DATA_W'(32'hAA), 5'd10);
    tick();
    chk("areset_first_valid", 128'(out_valid), 128'd1);
    chk("areset_first_data", 128'(out_data), 128'hAA);
    drive(1'b0, '0, '0, '0);
    tick();
    chk("areset_drained", 128'(out_valid), 128'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
